// File: rtl/sumador_pkg.sv
// Shared types and elaboration helpers for the serial adder/subtractor.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package sumador_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int num_chunks(input int width, input int k);
        return width / k;
    endfunction

    function automatic int cnt_width(input int width, input int k);
        return $clog2(width / k + 1);
    endfunction

    function automatic bit split_ok(input int width, input int k);
        return (width >= 2) && (k >= 1) && (k <= width) && ((width % k) == 0);
    endfunction

endpackage

// File: rtl/sumador_slice.sv
// Combinational K-bit ripple adder chunk built from full-adder cells.
// Latency: zero (pure combinational).
// Backpressure: none; evaluated every cycle by the parent.
module sumador_slice
    import sumador_pkg::*;
#(
    parameter int K = 1
) (
    input  logic [K-1:0] a,
    input  logic [K-1:0] b,
    input  logic         ci,
    output logic [K-1:0] s,
    output logic         co,
    output logic         c_msb
);

    logic [K:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < K; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    // Carry into the chunk MSB; only the last chunk's value feeds overflow.
    assign c_msb = c[K-1];
    assign co    = c[K];

endmodule

// File: rtl/sumador_serial.sv
// Multi-cycle WIDTH-bit adder/subtractor, K bits per clock, carry FF chains chunks.
// Latency: WIDTH/K cycles from accepted start to done; back-to-back accepted from DONE.
// Backpressure: start is ignored while busy; result holds until the next completion.
module sumador_serial
    import sumador_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int K     = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] O,
    output logic             Co,
    output logic             ovf
);

    localparam int N  = num_chunks(WIDTH, K);
    localparam int CW = cnt_width(WIDTH, K);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if (!split_ok(WIDTH, K)) begin : g_bad_split
        $error("sumador_serial: WIDTH must be >= 2 and a multiple of K");
    end

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_reg, b_reg, res_reg, res_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [K-1:0]     sum_k;
    logic             co_k, cmsb_k;
    logic             accept, last;

    assign accept = start && (state != RUN);
    assign last   = (state == RUN) && (cnt == LAST);

    sumador_slice #(.K(K)) u_slice (
        .a     (a_reg[K-1:0]),
        .b     (b_reg[K-1:0]),
        .ci    (carry),
        .s     (sum_k),
        .co    (co_k),
        .c_msb (cmsb_k)
    );

    // New sum bits enter from the MSB side so the LSB chunk ends up at bit 0.
    if (K == WIDTH) begin : g_res_full
        assign res_nxt = sum_k;
    end else begin : g_res_shift
        assign res_nxt = {sum_k, res_reg[WIDTH-1:K]};
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            res_reg <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            O       <= '0;
            Co      <= 1'b0;
            ovf     <= 1'b0;
        end else if (accept) begin
            // Subtraction is A + ~B + ~Ci, so Ci behaves as a borrow-in.
            a_reg <= A;
            b_reg <= sub ? ~B : B;
            carry <= Ci ^ sub;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_reg   <= a_reg >> K;
            b_reg   <= b_reg >> K;
            carry   <= co_k;
            cnt     <= cnt + 1'b1;
            res_reg <= res_nxt;
            if (last) begin
                O   <= res_nxt;
                Co  <= co_k;
                ovf <= co_k ^ cmsb_k;
            end
        end
    end

endmodule

// File: tb/tb_sumador_serial.sv
// Self-checking bench for sumador_serial: K=1 main instance plus K=2/4/8 instances.
module tb_sumador_serial;

    localparam int W = 8;
    localparam int LAT [4] = '{8, 4, 2, 1};

    typedef logic [W+1:0] exp_t;   // {Co, ovf, O}

    logic         clk = 1'b0;
    logic         rst, start_m, start_x, sub, ci;
    logic [W-1:0] a, b;
    logic         busy_k [4];
    logic         done_k [4];
    logic         co_k   [4];
    logic         ovf_k  [4];
    logic [W-1:0] o_k    [4];

    exp_t q0[$], q1[$], q2[$], q3[$];
    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    sumador_serial #(.WIDTH(W), .K(1)) dut (
        .clk(clk), .rst(rst), .start(start_m), .sub(sub), .A(a), .B(b), .Ci(ci),
        .busy(busy_k[0]), .done(done_k[0]), .O(o_k[0]), .Co(co_k[0]), .ovf(ovf_k[0]));
    sumador_serial #(.WIDTH(W), .K(2)) dut_k2 (
        .clk(clk), .rst(rst), .start(start_x), .sub(sub), .A(a), .B(b), .Ci(ci),
        .busy(busy_k[1]), .done(done_k[1]), .O(o_k[1]), .Co(co_k[1]), .ovf(ovf_k[1]));
    sumador_serial #(.WIDTH(W), .K(4)) dut_k4 (
        .clk(clk), .rst(rst), .start(start_x), .sub(sub), .A(a), .B(b), .Ci(ci),
        .busy(busy_k[2]), .done(done_k[2]), .O(o_k[2]), .Co(co_k[2]), .ovf(ovf_k[2]));
    sumador_serial #(.WIDTH(W), .K(8)) dut_k8 (
        .clk(clk), .rst(rst), .start(start_x), .sub(sub), .A(a), .B(b), .Ci(ci),
        .busy(busy_k[3]), .done(done_k[3]), .O(o_k[3]), .Co(co_k[3]), .ovf(ovf_k[3]));

    // Reference: integer arithmetic, signed range check for overflow, borrow for sub Co.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c, input logic s);
        int r, sr, sx, sy;
        logic co, ov;
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (!s) begin
            r  = int'(x) + int'(y) + int'(c);
            sr = sx + sy + int'(c);
            co = (r >= (1 << W));
        end else begin
            r  = int'(x) - int'(y) - int'(c);
            sr = sx - sy - int'(c);
            co = (r >= 0);
        end
        ov = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
        return {co, ov, r[W-1:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input int k, input exp_t e);
        if (k == 0) q0.push_back(e);
        else if (k == 1) q1.push_back(e);
        else if (k == 2) q2.push_back(e);
        else q3.push_back(e);
    endtask

    task automatic sb_pop(input int k, output exp_t e, output bit ok);
        ok = 1'b1;
        e  = '0;
        if (k == 0)      begin if (q0.size() > 0) e = q0.pop_front(); else ok = 1'b0; end
        else if (k == 1) begin if (q1.size() > 0) e = q1.pop_front(); else ok = 1'b0; end
        else if (k == 2) begin if (q2.size() > 0) e = q2.pop_front(); else ok = 1'b0; end
        else             begin if (q3.size() > 0) e = q3.pop_front(); else ok = 1'b0; end
    endtask

    function automatic int sb_size(input int k);
        if (k == 0) return q0.size();
        if (k == 1) return q1.size();
        if (k == 2) return q2.size();
        return q3.size();
    endfunction

    // Drives one start pulse; returns just after the accepting edge.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                         input logic s, input exp_t e, input bit all);
        a = x; b = y; ci = c; sub = s;
        start_m = 1'b1;
        start_x = all;
        sb_push(0, e);
        if (all) for (int k = 1; k < 4; k++) sb_push(k, e);
        tick();
        start_m = 1'b0;
        start_x = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_m = 1'b0; start_x = 1'b0; sub = 1'b0; ci = 1'b0; a = '0; b = '0;
        tick();
        tick();
        total++; if (busy_k[0] !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy_k[0]); else passed++;
        total++; if (done_k[0] !== 1'b0) $display("FAIL reset_done: got %b expected 0", done_k[0]); else passed++;
        total++; if (o_k[0] !== '0) $display("FAIL reset_O: got %h expected 00", o_k[0]); else passed++;
        total++; if (co_k[0] !== 1'b0) $display("FAIL reset_Co: got %b expected 0", co_k[0]); else passed++;
        total++; if (ovf_k[0] !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", ovf_k[0]); else passed++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_vectors();
        logic [W-1:0] va [5] = '{8'h5A, 8'h10, 8'h80, 8'hFF, 8'h7F};
        logic [W-1:0] vb [5] = '{8'h33, 8'h20, 8'h01, 8'h01, 8'h00};
        logic         vc [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic         vs [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_t         ve [5] = '{{2'b01, 8'h8D}, {2'b00, 8'hF0}, {2'b11, 8'h7F},
                                 {2'b10, 8'h01}, {2'b01, 8'h80}};
        for (int v = 0; v < 5; v++) begin
            bit   seen [4] = '{0, 0, 0, 0};
            exp_t e;
            bit   ok;
            issue(va[v], vb[v], vc[v], vs[v], ve[v], 1'b1);
            total++; if (busy_k[0] !== 1'b1) $display("FAIL vec%0d_busy_at_accept: got %b expected 1", v, busy_k[0]); else passed++;
            for (int c = 1; c <= 12; c++) begin
                tick();
                if (c < 8 && busy_k[0] !== 1'b1) begin
                    total++; $display("FAIL vec%0d_busy_c%0d: got %b expected 1", v, c, busy_k[0]);
                end
                for (int k = 0; k < 4; k++) begin
                    if (done_k[k] === 1'b1) begin
                        sb_pop(k, e, ok);
                        total++;
                        if (!ok) $display("FAIL vec%0d_k%0d_extra_done: got done expected none", v, k);
                        else if ({co_k[k], ovf_k[k], o_k[k]} !== e)
                            $display("FAIL vec%0d_k%0d_result: got %h expected %h", v, k, {co_k[k], ovf_k[k], o_k[k]}, e);
                        else passed++;
                        total++;
                        if (c !== LAT[k]) $display("FAIL vec%0d_k%0d_latency: got %0d expected %0d", v, k, c, LAT[k]);
                        else passed++;
                        seen[k] = 1'b1;
                    end
                end
            end
            for (int k = 0; k < 4; k++) begin
                total++; if (!seen[k]) $display("FAIL vec%0d_k%0d_timeout: got no done expected done", v, k); else passed++;
            end
        end
    endtask

    task automatic test_ignored_start();
        int   ndone = 0;
        exp_t e;
        bit   ok;
        issue(8'h12, 8'h34, 1'b0, 1'b0, model(8'h12, 8'h34, 1'b0, 1'b0), 1'b0);
        tick();
        tick();
        a = 8'hF0; b = 8'hF0; ci = 1'b1; sub = 1'b1; start_m = 1'b1;
        tick();
        start_m = 1'b0;
        for (int c = 4; c <= 16; c++) begin
            tick();
            if (done_k[0] === 1'b1) begin
                ndone++;
                sb_pop(0, e, ok);
                total++;
                if (!ok || {co_k[0], ovf_k[0], o_k[0]} !== e)
                    $display("FAIL ignored_start_result: got %h expected %h", {co_k[0], ovf_k[0], o_k[0]}, e);
                else passed++;
                total++; if (c !== 8) $display("FAIL ignored_start_latency: got %0d expected 8", c); else passed++;
            end
        end
        total++; if (ndone !== 1) $display("FAIL ignored_start_done_count: got %0d expected 1", ndone); else passed++;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        bit   ok;
        bit   got1 = 1'b0;
        bit   got2 = 1'b0;
        issue(8'h0F, 8'h0F, 1'b0, 1'b0, model(8'h0F, 8'h0F, 1'b0, 1'b0), 1'b0);
        start_m = 1'b1;
        a = 8'hC8; b = 8'h64; ci = 1'b1; sub = 1'b1;
        sb_push(0, model(8'hC8, 8'h64, 1'b1, 1'b1));
        for (int c = 1; c <= 12 && !got1; c++) begin
            tick();
            if (done_k[0] === 1'b1) begin
                got1 = 1'b1;
                sb_pop(0, e, ok);
                total++;
                if (!ok || {co_k[0], ovf_k[0], o_k[0]} !== e)
                    $display("FAIL b2b_first_result: got %h expected %h", {co_k[0], ovf_k[0], o_k[0]}, e);
                else passed++;
            end
        end
        total++; if (!got1) $display("FAIL b2b_first_timeout: got no done expected done"); else passed++;
        tick();
        start_m = 1'b0;
        total++; if (busy_k[0] !== 1'b1) $display("FAIL b2b_no_idle_busy: got %b expected 1", busy_k[0]); else passed++;
        for (int c = 1; c <= 12 && !got2; c++) begin
            tick();
            if (done_k[0] === 1'b1) begin
                got2 = 1'b1;
                sb_pop(0, e, ok);
                total++;
                if (!ok || {co_k[0], ovf_k[0], o_k[0]} !== e)
                    $display("FAIL b2b_second_result: got %h expected %h", {co_k[0], ovf_k[0], o_k[0]}, e);
                else passed++;
                total++; if (c !== 8) $display("FAIL b2b_second_latency: got %0d expected 8", c); else passed++;
            end
        end
        total++; if (!got2) $display("FAIL b2b_second_timeout: got no done expected done"); else passed++;
        tick();
    endtask

    task automatic test_reset_mid();
        int   ndone = 0;
        bit   got = 1'b0;
        exp_t e;
        bit   ok;
        issue(8'hAA, 8'h11, 1'b0, 1'b0, model(8'hAA, 8'h11, 1'b0, 1'b0), 1'b0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        q0.delete();
        total++; if (busy_k[0] !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", busy_k[0]); else passed++;
        total++; if (o_k[0] !== '0) $display("FAIL midrst_O: got %h expected 00", o_k[0]); else passed++;
        total++; if (co_k[0] !== 1'b0) $display("FAIL midrst_Co: got %b expected 0", co_k[0]); else passed++;
        total++; if (ovf_k[0] !== 1'b0) $display("FAIL midrst_ovf: got %b expected 0", ovf_k[0]); else passed++;
        for (int c = 0; c < 12; c++) begin
            if (done_k[0] === 1'b1) ndone++;
            tick();
        end
        total++; if (ndone !== 0) $display("FAIL midrst_done_count: got %0d expected 0", ndone); else passed++;
        issue(8'h5A, 8'h33, 1'b0, 1'b0, {2'b01, 8'h8D}, 1'b0);
        for (int c = 1; c <= 12 && !got; c++) begin
            tick();
            if (done_k[0] === 1'b1) begin
                got = 1'b1;
                sb_pop(0, e, ok);
                total++;
                if (!ok || {co_k[0], ovf_k[0], o_k[0]} !== e)
                    $display("FAIL midrst_fresh_result: got %h expected %h", {co_k[0], ovf_k[0], o_k[0]}, e);
                else passed++;
            end
        end
        total++; if (!got) $display("FAIL midrst_fresh_timeout: got no done expected done"); else passed++;
        tick();
    endtask

    task automatic test_random();
        logic [W-1:0] x, y;
        logic         c, s;
        exp_t         e;
        bit           ok;
        int           nerr = 0;
        for (int n = 0; n < 1000; n++) begin
            x = W'($urandom);
            y = W'($urandom);
            c = 1'($urandom);
            s = 1'($urandom);
            issue(x, y, c, s, model(x, y, c, s), 1'b1);
            for (int t = 1; t <= 9; t++) begin
                tick();
                for (int k = 0; k < 4; k++) begin
                    if (done_k[k] === 1'b1) begin
                        sb_pop(k, e, ok);
                        total++;
                        if (!ok || {co_k[k], ovf_k[k], o_k[k]} !== e) begin
                            nerr++;
                            if (nerr <= 10)
                                $display("FAIL rand%0d_k%0d: got %h expected %h (A=%h B=%h Ci=%b sub=%b)",
                                         n, k, {co_k[k], ovf_k[k], o_k[k]}, e, x, y, c, s);
                        end else passed++;
                    end
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (sb_size(k) !== 0) $display("FAIL rand_k%0d_missing: got %0d pending expected 0", k, sb_size(k));
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sumador_serial.md
Name: sumador_serial

Overview:
- Parametrised multi-cycle adder/subtractor that processes WIDTH-bit operands K bits per clock.
- A single carry flip-flop chains the chunks together.
- Start/busy/done handshake; result held until the next operation.
- Used where a full-width combinational adder is too large or too slow: datapath accumulation, ALU back-end, serial links.

Parameters:
- WIDTH, 8, operand and result width in bits; must be ≥ 2.
- K, 1, bits processed per cycle. WIDTH % K must equal 0; elaboration error otherwise.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request a new operation; sampled only when not busy.
- sub  input  1  0 = A+B+Ci, 1 = A−B−Ci (Ci acts as borrow-in).
- A  input  WIDTH  operand A, sampled on the accepted start edge.
- B  input  WIDTH  operand B, sampled on the accepted start edge.
- Ci  input  1  carry-in (add) / borrow-in (sub), sampled with A and B.
- busy  output  1  high while the operation is in progress.
- done  output  1  single-cycle pulse when O, Co and ovf become valid.
- O  output  WIDTH  result; holds until the next accepted start.
- Co  output  1  raw carry-out of the MSB. In sub mode, 1 = no borrow.
- ovf  output  1  two's-complement overflow (carry into MSB XOR carry out of MSB).

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Reset: on any edge with rst=1, state returns to IDLE and all outputs clear (busy=0, done=0, O=0, Co=0, ovf=0). Internal A/B shift registers, carry FF and chunk counter also clear.
- Reset mid-operation aborts the operation. No done pulse is produced and the partial result is discarded.
- States: IDLE, RUN, DONE. N = WIDTH/K.
- IDLE or DONE with start=1 at edge t:
  - Latch A into the A register.
  - Latch B into the B register, or ~B when sub=1.
  - Load the carry FF with Ci, or ~Ci when sub=1.
  - Clear the counter; go to RUN; busy=1 from t.
- Start is accepted in DONE, so back-to-back operations have no idle cycle.
- RUN, each edge:
  - Add the K LSBs of A and B plus the carry FF.
  - Shift the K sum bits into the result register from the MSB side.
  - Shift the operand registers right by K; update the carry FF; increment the counter.
  - On the N-th RUN edge: load O, Co and ovf from the final values; go to DONE; busy=0; done=1.
- DONE, one cycle: done=0 on the next edge. Go to IDLE unless start=1, in which case accept the new operation as above.
- Latency: accepted start at edge t → done=1 and O valid after edge t+N. Throughput is one operation per N+1 cycles.
- start while busy=1 is ignored; A, B, Ci and sub changes during RUN have no effect.
- O, Co and ovf update only on the N-th RUN edge and otherwise hold, including during the next RUN.
- ovf is computed in the final chunk from the carry into bit WIDTH−1 and the carry out of bit WIDTH−1.
- Wrap-around: the sum is modulo 2^WIDTH; excess is reported only via Co and ovf.

Decomposition:
- Package sumador_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - helper function for N = WIDTH/K and counter width $clog2(N+1);
  - the WIDTH % K check.
- One natural sub-module: sumador_slice, a combinational K-bit ripple adder built from 1-bit full-adder cells. It outputs the K sum bits, the carry-out, and the carry into its MSB (needed for ovf).
- Control FSM and registers stay in sumador_serial.

Test Plan:
- WIDTH=8,K=1, add A=0x5A, B=0x33, Ci=0, start at edge t → busy high for t..t+7; done=1 after edge t+8; O=0x8D, Co=0, ovf=1.
- Sub A=0x10, B=0x20, Ci=0 → O=0xF0, Co=0 (borrow), ovf=0. Sub A=0x80, B=0x01, Ci=0 → O=0x7F, Co=1, ovf=1.
- Add A=0xFF, B=0x01, Ci=1 → O=0x01, Co=1, ovf=0. Add A=0x7F, B=0x00, Ci=1 → O=0x80, ovf=1.
- Pulse start again at t+3 with different operands → ignored. First result is unchanged and exactly one done pulse occurs. start held high in DONE → second operation begins with no IDLE cycle.
- rst=1 at edge t+4 of an operation → busy=0, O=0, Co=0, ovf=0 after that edge; no done pulse. A fresh start afterwards gives the correct result.
- K=4 and K=8 builds, first vector → done after edge t+2 and t+1 respectively; O=0x8D, Co=0, ovf=1. Randomised 1000-vector compare against a reference model for K ∈ {1,2,4,8}.
